// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch, data-read and data-write requests
// onto one single-port RAM. Writes are posted into an in-order write buffer.
// Reads that hit a buffered write address wait for it to drain. Each
// one-cycle-latency read response is steered back to the port that issued it.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   iready/iaddr -> igrant          instruction read request / issue strobe
//   iresp/idata                     instruction read response
//   drready/draddr -> drgrant       data read request / issue strobe
//   drresp/drdata                   data read response
//   dwready/dwaddr/dwdata/dwstrb    data write request; dwgrant = accepted
//   wbuf_empty                      write buffer empty (fence support)
//   mready/mwe/maddr/mwdata/mwstrb  memory access port
//   mrresp/mrdata                   memory read response (one cycle after read)
module mem_arbiter #(
  parameter int unsigned WBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iready,
  input  logic [29:0] iaddr,
  output logic        igrant,
  output logic        iresp,
  output logic [31:0] idata,
  input  logic        drready,
  input  logic [29:0] draddr,
  output logic        drgrant,
  output logic        drresp,
  output logic [31:0] drdata,
  input  logic        dwready,
  input  logic [29:0] dwaddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstrb,
  output logic        dwgrant,
  output logic        wbuf_empty,
  output logic        mready,
  output logic        mwe,
  output logic [29:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mwstrb,
  input  logic        mrresp,
  input  logic [31:0] mrdata
);

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned PW = $clog2(WBUF_DEPTH);

  // Write buffer storage and per-slot occupancy
  logic [AW-1:0]         wb_addr [WBUF_DEPTH];
  logic [DW-1:0]         wb_data [WBUF_DEPTH];
  logic [SW-1:0]         wb_strb [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] wb_valid;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;

  logic rr_d;       // 1: next read tie goes to the data port
  logic tag_valid;  // a read was issued last cycle
  logic tag_d;      // that read belongs to the data port

  logic [AW-1:0] maddr_q;
  logic [DW-1:0] mwdata_q;
  logic [SW-1:0] mwstrb_q;
  logic [DW-1:0] idata_q;
  logic [DW-1:0] drdata_q;

  logic full;
  logic i_hit;
  logic d_hit;
  logic i_ok;
  logic d_ok;
  logic drain;
  logic issue_i;
  logic issue_d;
  logic tie;
  logic enq;

  assign full       = &wb_valid;
  assign wbuf_empty = ~|wb_valid;

  // Read-after-write hazard against buffered (not incoming) writes
  always_comb begin
    i_hit = 1'b0;
    d_hit = 1'b0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if (wb_valid[PW'(k)] && (wb_addr[PW'(k)] == iaddr))  i_hit = 1'b1;
      if (wb_valid[PW'(k)] && (wb_addr[PW'(k)] == draddr)) d_hit = 1'b1;
    end
  end

  assign i_ok = iready && !i_hit;
  assign d_ok = drready && !d_hit;

  // Per-cycle memory port decision; priority order matters
  always_comb begin
    drain   = 1'b0;
    issue_i = 1'b0;
    issue_d = 1'b0;
    tie     = 1'b0;
    if (!reset) begin
      if (full) begin
        drain = 1'b1;
      end else if (i_ok && d_ok) begin
        tie     = 1'b1;
        issue_d = rr_d;
        issue_i = !rr_d;
      end else if (i_ok) begin
        issue_i = 1'b1;
      end else if (d_ok) begin
        issue_d = 1'b1;
      end else if (!wbuf_empty) begin
        drain = 1'b1;
      end
    end
  end

  assign igrant  = issue_i;
  assign drgrant = issue_d;
  assign dwgrant = !reset && dwready && !full;
  // Zero-strobe writes are acknowledged but never stored
  assign enq     = dwgrant && (dwstrb != 4'h0);

  assign mready = drain || issue_i || issue_d;
  assign mwe    = drain;
  assign maddr  = drain   ? wb_addr[head] :
                  issue_i ? iaddr :
                  issue_d ? draddr : maddr_q;
  assign mwdata = drain ? wb_data[head] : mwdata_q;
  assign mwstrb = drain ? wb_strb[head] : mwstrb_q;

  // Response steering by the tag of last cycle's read
  assign iresp  = !reset && mrresp && tag_valid && !tag_d;
  assign drresp = !reset && mrresp && tag_valid && tag_d;
  assign idata  = iresp  ? mrdata : idata_q;
  assign drdata = drresp ? mrdata : drdata_q;

  // Buffer payload needs no reset; occupancy is tracked by wb_valid
  always_ff @(posedge clk) begin
    if (enq) begin
      wb_addr[tail] <= dwaddr;
      wb_data[tail] <= dwdata;
      wb_strb[tail] <= dwstrb;
    end
  end

  // Control state and held output values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid  <= '0;
      head      <= '0;
      tail      <= '0;
      rr_d      <= 1'b1;
      tag_valid <= 1'b0;
      tag_d     <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      mwstrb_q  <= '0;
      idata_q   <= '0;
      drdata_q  <= '0;
    end else begin
      if (enq) begin
        wb_valid[tail] <= 1'b1;
        tail           <= tail + PW'(1);
      end
      if (drain) begin
        wb_valid[head] <= 1'b0;
        head           <= head + PW'(1);
      end
      if (tie) rr_d <= !rr_d;
      tag_valid <= issue_i || issue_d;
      tag_d     <= issue_d;
      maddr_q   <= maddr;
      mwdata_q  <= mwdata;
      mwstrb_q  <= mwstrb;
      idata_q   <= idata;
      drdata_q  <= drdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, reset corner sequence and a random
// phase checked against a queue-based model of the arbiter's rules.
module tb_mem_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned NRAND = 3000;
  localparam logic [31:0] INIT  = 32'hA500_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        iready, drready, dwready;
  logic [29:0] iaddr, draddr, dwaddr;
  logic [31:0] dwdata;
  logic [3:0]  dwstrb;
  logic        igrant, iresp, drgrant, drresp, dwgrant, wbuf_empty;
  logic [31:0] idata, drdata;
  logic        mready, mwe, mrresp;
  logic [29:0] maddr;
  logic [31:0] mwdata, mrdata;
  logic [3:0]  mwstrb;

  logic        mem_resp;
  logic        force_resp;
  logic [31:0] ram [256];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .iready(iready), .iaddr(iaddr), .igrant(igrant), .iresp(iresp), .idata(idata),
    .drready(drready), .draddr(draddr), .drgrant(drgrant), .drresp(drresp), .drdata(drdata),
    .dwready(dwready), .dwaddr(dwaddr), .dwdata(dwdata), .dwstrb(dwstrb), .dwgrant(dwgrant),
    .wbuf_empty(wbuf_empty),
    .mready(mready), .mwe(mwe), .maddr(maddr), .mwdata(mwdata), .mwstrb(mwstrb),
    .mrresp(mrresp), .mrdata(mrdata)
  );

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Single-port RAM: byte-masked writes, read data one cycle after the strobe
  assign mrresp = mem_resp | force_resp;
  always @(posedge clk) begin
    mem_resp <= mready && !mwe;
    mrdata   <= ram[maddr[7:0]];
    if (mready && mwe) ram[maddr[7:0]] <= merge(ram[maddr[7:0]], mwdata, mwstrb);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic ir; logic [29:0] ia;
    logic dr; logic [29:0] da;
    logic dw; logic [29:0] wa; logic [31:0] wd; logic [3:0] ws;
    logic eig, edg, ewg, emr, emwe;
    logic [29:0] ema; logic [31:0] emwd;
    logic eir, edr; logic [31:0] erd;
    logic eemp;
  } vec_t;

  function automatic vec_t mk(
      logic ir, logic [29:0] ia, logic dr, logic [29:0] da,
      logic dw, logic [29:0] wa, logic [31:0] wd, logic [3:0] ws,
      logic eig, logic edg, logic ewg, logic emr, logic emwe,
      logic [29:0] ema, logic [31:0] emwd,
      logic eir, logic edr, logic [31:0] erd, logic eemp);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.da = da;
    v.dw = dw; v.wa = wa; v.wd = wd; v.ws = ws;
    v.eig = eig; v.edg = edg; v.ewg = ewg; v.emr = emr; v.emwe = emwe;
    v.ema = ema; v.emwd = emwd;
    v.eir = eir; v.edr = edr; v.erd = erd; v.eemp = eemp;
    return v;
  endfunction

  // Drive one cycle's inputs (called just after a rising edge), check at the falling edge
  task automatic run_vec(vec_t v, int idx);
    string tag;
    iready = v.ir; iaddr = v.ia;
    drready = v.dr; draddr = v.da;
    dwready = v.dw; dwaddr = v.wa; dwdata = v.wd; dwstrb = v.ws;
    @(negedge clk);
    tag = $sformatf("v%0d", idx);
    chk({tag, " igrant"},     32'(igrant),     32'(v.eig));
    chk({tag, " drgrant"},    32'(drgrant),    32'(v.edg));
    chk({tag, " dwgrant"},    32'(dwgrant),    32'(v.ewg));
    chk({tag, " mready"},     32'(mready),     32'(v.emr));
    chk({tag, " mwe"},        32'(mwe),        32'(v.emwe));
    if (v.emr)  chk({tag, " maddr"},  32'(maddr), 32'(v.ema));
    if (v.emwe) chk({tag, " mwdata"}, mwdata,     v.emwd);
    chk({tag, " iresp"},      32'(iresp),      32'(v.eir));
    chk({tag, " drresp"},     32'(drresp),     32'(v.edr));
    if (v.eir)  chk({tag, " idata"},  idata,      v.erd);
    if (v.edr)  chk({tag, " drdata"}, drdata,     v.erd);
    chk({tag, " wbuf_empty"}, 32'(wbuf_empty), 32'(v.eemp));
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  vec_t tbl[$];
  vec_t hs[$];
  vec_t zero_v;

  // Random-phase reference model state
  wr_t         wq[$];
  logic [31:0] arch [256];
  logic        fav_d;
  logic        pend_i, pend_d;
  logic [31:0] pend_idata, pend_ddata;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]  = INIT | 32'(i);
      arch[i] = INIT | 32'(i);
    end
    force_resp = 1'b0;
    reset = 1'b1;
    zero_v = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 0,0,0, 1);

    //            ir ia     dr da     dw wa     wd            ws    ig dg wg mr we ma     mwd           ir dr rd                   emp
    tbl.push_back(mk(1,'h10, 0,0,     0,0,     0,            0,    1,0,0,1,0,'h10, 0,            0,0,0,                  1));
    tbl.push_back(mk(1,'h11, 0,0,     0,0,     0,            0,    1,0,0,1,0,'h11, 0,            1,0,INIT|32'h10,       1));
    tbl.push_back(mk(0,0,    0,0,     0,0,     0,            0,    0,0,0,0,0,0,    0,            1,0,INIT|32'h11,       1));
    tbl.push_back(mk(1,'h20, 1,'h21,  0,0,     0,            0,    0,1,0,1,0,'h21, 0,            0,0,0,                  1));
    tbl.push_back(mk(1,'h20, 1,'h21,  0,0,     0,            0,    1,0,0,1,0,'h20, 0,            0,1,INIT|32'h21,       1));
    tbl.push_back(mk(1,'h20, 1,'h21,  0,0,     0,            0,    0,1,0,1,0,'h21, 0,            1,0,INIT|32'h20,       1));
    tbl.push_back(mk(1,'h20, 1,'h21,  0,0,     0,            0,    1,0,0,1,0,'h20, 0,            0,1,INIT|32'h21,       1));
    tbl.push_back(mk(0,0,    0,0,     0,0,     0,            0,    0,0,0,0,0,0,    0,            1,0,INIT|32'h20,       1));
    tbl.push_back(mk(0,0,    0,0,     1,'h40,  32'hDEADBEEF, 4'hF, 0,0,1,0,0,0,    0,            0,0,0,                  1));
    tbl.push_back(mk(0,0,    1,'h40,  0,0,     0,            0,    0,0,0,1,1,'h40, 32'hDEADBEEF, 0,0,0,                  0));
    tbl.push_back(mk(0,0,    1,'h40,  0,0,     0,            0,    0,1,0,1,0,'h40, 0,            0,0,0,                  1));
    tbl.push_back(mk(0,0,    0,0,     0,0,     0,            0,    0,0,0,0,0,0,    0,            0,1,32'hDEADBEEF,       1));
    tbl.push_back(mk(0,0,    0,0,     1,'h40,  32'h11111111, 4'hF, 0,0,1,0,0,0,    0,            0,0,0,                  1));
    tbl.push_back(mk(0,0,    1,'h41,  0,0,     0,            0,    0,1,0,1,0,'h41, 0,            0,0,0,                  0));
    tbl.push_back(mk(0,0,    0,0,     0,0,     0,            0,    0,0,0,1,1,'h40, 32'h11111111, 0,1,INIT|32'h41,       0));
    tbl.push_back(mk(0,0,    0,0,     0,0,     0,            0,    0,0,0,0,0,0,    0,            0,0,0,                  1));
    tbl.push_back(mk(0,0,    0,0,     1,'h50,  32'h0BAD0BAD, 4'h0, 0,0,1,0,0,0,    0,            0,0,0,                  1));
    tbl.push_back(mk(0,0,    0,0,     0,0,     0,            0,    0,0,0,0,0,0,    0,            0,0,0,                  1));
    tbl.push_back(mk(0,0,    1,'h50,  0,0,     0,            0,    0,1,0,1,0,'h50, 0,            0,0,0,                  1));
    tbl.push_back(mk(0,0,    0,0,     0,0,     0,            0,    0,0,0,0,0,0,    0,            0,1,INIT|32'h50,       1));
    tbl.push_back(mk(1,'h10, 0,0,     1,'h60,  32'h60606060, 4'hF, 1,0,1,1,0,'h10, 0,            0,0,0,                  1));
    tbl.push_back(mk(1,'h11, 0,0,     1,'h61,  32'h61616161, 4'hF, 1,0,1,1,0,'h11, 0,            1,0,INIT|32'h10,       0));
    tbl.push_back(mk(1,'h12, 0,0,     1,'h62,  32'h62626262, 4'hF, 0,0,0,1,1,'h60, 32'h60606060, 1,0,INIT|32'h11,       0));
    tbl.push_back(mk(1,'h12, 0,0,     1,'h62,  32'h62626262, 4'hF, 1,0,1,1,0,'h12, 0,            0,0,0,                  0));
    tbl.push_back(mk(1,'h13, 0,0,     0,0,     0,            0,    0,0,0,1,1,'h61, 32'h61616161, 1,0,INIT|32'h12,       0));
    tbl.push_back(mk(1,'h13, 0,0,     0,0,     0,            0,    1,0,0,1,0,'h13, 0,            0,0,0,                  0));
    tbl.push_back(mk(0,0,    0,0,     0,0,     0,            0,    0,0,0,1,1,'h62, 32'h62626262, 1,0,INIT|32'h13,       0));
    tbl.push_back(mk(0,0,    0,0,     0,0,     0,            0,    0,0,0,0,0,0,    0,            0,0,0,                  1));
    tbl.push_back(mk(0,0,    1,'h62,  0,0,     0,            0,    0,1,0,1,0,'h62, 0,            0,0,0,                  1));
    tbl.push_back(mk(0,0,    0,0,     0,0,     0,            0,    0,0,0,0,0,0,    0,            0,1,32'h62626262,       1));

    // Reset state
    iready = 0; iaddr = 0; drready = 0; draddr = 0;
    dwready = 0; dwaddr = 0; dwdata = 0; dwstrb = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst igrant",     32'(igrant),     0);
    chk("rst drgrant",    32'(drgrant),    0);
    chk("rst mready",     32'(mready),     0);
    chk("rst mwe",        32'(mwe),        0);
    chk("rst maddr",      32'(maddr),      0);
    chk("rst idata",      idata,           0);
    chk("rst drdata",     drdata,          0);
    chk("rst wbuf_empty", 32'(wbuf_empty), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Reset one cycle after a read grant with two writes buffered
    run_vec(mk(1,'h10, 0,0, 1,'h70, 32'h70707070, 4'hF, 1,0,1,1,0,'h10, 0, 0,0,0, 1), 100);
    run_vec(mk(1,'h11, 0,0, 1,'h71, 32'h71717171, 4'hF, 1,0,1,1,0,'h11, 0, 1,0,INIT|32'h10, 0), 101);
    reset = 1'b1;
    run_vec(zero_v, 102);
    reset = 1'b0;
    force_resp = 1'b1;   // stray response with no read outstanding
    run_vec(zero_v, 103);
    force_resp = 1'b0;
    hs.push_back(mk(0,0, 1,'h70, 0,0,0,0, 0,1,0,1,0,'h70, 0, 0,0,0, 1));
    hs.push_back(mk(0,0, 0,0,    0,0,0,0, 0,0,0,0,0,0,    0, 0,1,INIT|32'h70, 1));
    foreach (hs[i]) run_vec(hs[i], 104 + i);

    // Random traffic against the rule-level model
    fav_d = 1'b1;
    pend_i = 1'b0; pend_d = 1'b0;
    pend_idata = '0; pend_ddata = '0;
    iready = 0; drready = 0; dwready = 0;
    for (int c = 0; c < NRAND; c++) begin
      logic blk_i, blk_d, i_ok, d_ok, full;
      logic e_drain, e_ig, e_dg, e_wg, e_mr;
      logic [29:0] e_ma;
      if (!iready && $urandom_range(0, 2) != 0) begin
        iready = 1; iaddr = 30'h80 + 30'($urandom_range(0, 7));
      end
      if (!drready && $urandom_range(0, 2) != 0) begin
        drready = 1; draddr = 30'h80 + 30'($urandom_range(0, 7));
      end
      if (!dwready && $urandom_range(0, 1) != 0) begin
        dwready = 1; dwaddr = 30'h80 + 30'($urandom_range(0, 7));
        dwdata = $urandom;
        dwstrb = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      end
      @(negedge clk);
      blk_i = 0; blk_d = 0;
      foreach (wq[k]) begin
        if (wq[k].a == iaddr)  blk_i = 1;
        if (wq[k].a == draddr) blk_d = 1;
      end
      i_ok = iready && !blk_i;
      d_ok = drready && !blk_d;
      full = (wq.size() == DEPTH);
      e_drain = 0; e_ig = 0; e_dg = 0;
      if (full) e_drain = 1;
      else if (i_ok && d_ok) begin
        if (fav_d) e_dg = 1; else e_ig = 1;
        fav_d = !fav_d;
      end
      else if (i_ok) e_ig = 1;
      else if (d_ok) e_dg = 1;
      else if (wq.size() != 0) e_drain = 1;
      e_wg = dwready && !full;
      e_mr = e_drain || e_ig || e_dg;
      e_ma = e_drain ? wq[0].a : (e_ig ? iaddr : draddr);

      chk("rnd igrant",  32'(igrant),  32'(e_ig));
      chk("rnd drgrant", 32'(drgrant), 32'(e_dg));
      chk("rnd dwgrant", 32'(dwgrant), 32'(e_wg));
      chk("rnd mready",  32'(mready),  32'(e_mr));
      chk("rnd mwe",     32'(mwe),     32'(e_drain));
      if (e_mr) chk("rnd maddr", 32'(maddr), 32'(e_ma));
      if (e_drain) begin
        chk("rnd mwdata", mwdata,      wq[0].d);
        chk("rnd mwstrb", 32'(mwstrb), 32'(wq[0].s));
      end
      chk("rnd iresp",  32'(iresp),  32'(pend_i));
      chk("rnd drresp", 32'(drresp), 32'(pend_d));
      if (pend_i) chk("rnd idata",  idata,  pend_idata);
      if (pend_d) chk("rnd drdata", drdata, pend_ddata);
      chk("rnd wbuf_empty", 32'(wbuf_empty), 32'(wq.size() == 0));

      // A granted read sees every earlier accepted write, but not this cycle's
      pend_i = e_ig; pend_idata = arch[iaddr[7:0]];
      pend_d = e_dg; pend_ddata = arch[draddr[7:0]];
      if (e_drain) void'(wq.pop_front());
      if (e_wg && dwstrb != 4'h0) begin
        wq.push_back({dwaddr, dwdata, dwstrb});
        arch[dwaddr[7:0]] = merge(arch[dwaddr[7:0]], dwdata, dwstrb);
      end

      @(posedge clk);
      #1;
      if (e_ig) iready = 0;
      if (e_dg) drready = 0;
      if (e_wg) dwready = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter between the core's split instruction-fetch, data-read and data-write request ports and the single-port RAM model used in SINGLE_RAM builds.
- Arbitrates all three sources onto one ready/we port and posts writes into a small write buffer.
- Resolves read-after-write hazards against buffered writes.
- Routes each one-cycle-latency read response back to the requester that issued it.

Parameters:
WBUF_DEPTH, 2, write buffer entries; power of two, >=2.

Ports:
clk        in   1   clock
reset      in   1   asynchronous active-high reset
iready     in   1   instruction read request; held until igrant
iaddr      in   30  instruction word address [31:2]
igrant     out  1   instruction read issued to memory this cycle
iresp      out  1   instruction read data valid
idata      out  32  instruction read data
drready    in   1   data read request; held until drgrant
draddr     in   30  data read word address
drgrant    out  1   data read issued this cycle
drresp     out  1   data read data valid
drdata     out  32  data read data
dwready    in   1   data write request; held until dwgrant
dwaddr     in   30  data write word address
dwdata     in   32  write data
dwstrb     in   4   byte strobes
dwgrant    out  1   write accepted into buffer this cycle
wbuf_empty out  1   write buffer empty (for fence)
mready     out  1   memory access strobe
mwe        out  1   1 = write, 0 = read
maddr      out  30  memory word address
mwdata     out  32  memory write data
mwstrb     out  4   memory byte strobes
mrresp     in   1   memory read response (one cycle after read strobe)
mrdata     in   32  memory read data

Behaviour:
- Reset (async, active-high):
  - Buffer empty, outstanding-tag invalid, round-robin pointer favours data read.
  - All grant/resp/mready/mwe outputs 0, data outputs 0, wbuf_empty 1.
- Grants are combinational, same cycle; a request is consumed only in a cycle where its grant is 1.
- Write acceptance:
  - dwgrant = dwready && buffer not full; enqueue and dequeue in the same cycle are allowed.
  - A write with dwstrb==0 is granted but discarded (not enqueued).
- Buffer is a FIFO of {addr, data, strb}; drain is in order; each drain presents mready=1, mwe=1 and the head entry.
- Hazard: a read is blocked while any valid buffer entry has an equal word address. A same-cycle incoming write does not block; the read returns the old data.
- Per-cycle port decision, first match wins:
  1. Buffer full -> drain.
  2. Exactly one unblocked read pending -> issue it.
  3. Both reads pending and unblocked -> issue the one the round-robin pointer selects; the pointer then flips to the other.
  4. Buffer non-empty -> drain. This covers all-reads-blocked and no reads pending.
  5. Otherwise mready=0.
- Read issue: mready=1, mwe=0, maddr = requester address; record tag (I or D, valid).
- Response: in the cycle mrresp=1 with a valid tag, route mrdata to idata/iresp or drdata/drresp combinationally.
  - Exactly one resp pulses per issued read, latency 1 cycle after grant.
  - The tag is overwritten every cycle, so back-to-back reads are supported at full throughput.
- mrresp with an invalid tag (e.g. first cycle after reset) is ignored.
- Reset mid-operation: buffered writes are lost, the outstanding response is dropped, and no resp pulses after reset.
- Idle data outputs hold their last value; only the resp strobes are meaningful.

Test Plan:
- Back-to-back instruction reads 0x10, 0x11 with no data traffic -> igrant both cycles; iresp one cycle after each; idata = mem[0x10], mem[0x11]; memory port 100% busy.
- iready and drready asserted together for 4 cycles -> grants alternate D, I, D, I; each resp tagged to the correct port.
- Write 0xDEADBEEF strb 0xF to 0x40, then data read 0x40 next cycle -> read blocked until drain (mwe=1, maddr=0x40); drresp returns 0xDEADBEEF; read to 0x41 in the same situation is not blocked.
- Three writes with continuous instruction reads, WBUF_DEPTH=2 -> third dwgrant withheld until a forced drain when full; writes reach memory in order; wbuf_empty rises after the last drain.
- Write with dwstrb=0 -> dwgrant=1, no memory write, wbuf_empty stays 1.
- Assert reset one cycle after a read grant with 2 writes buffered -> no resp after reset, wbuf_empty=1, mready=0, then normal operation resumes.
